// File: rtl/pipe_mux_sel.sv
// Purpose     : registered N-input, WIDTH-bit select stage with a two-entry skid buffer.
// Latency     : 1 cycle from accept to out_* when the stage has room to forward directly.
// Backpressure: valid/ready; in_ready is registered and drops only when both entries are held.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_data             NUM_IN packed inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel              input index captured with each beat
//   in_valid / in_ready upstream handshake (in_ready comes straight from a flop)
//   flush               synchronous squash of every held beat and of a same-cycle accept
//   out_data / out_sel  registered beat: selected data plus the select it was taken with
//   out_valid/out_ready downstream handshake
//   sel_err             sticky out-of-range select flag (only with PIPE_MUX_RANGE_CHK_EN)
//
// Build option: define PIPE_MUX_RANGE_CHK_EN to add the sel_err port and its checker.
// Out-of-range selects capture all-zero data in either build.

module pipe_mux_sel #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
`ifdef PIPE_MUX_RANGE_CHK_EN
    output logic                    sel_err,
`endif
    input  logic                    out_ready
);

    // One captured beat: the selected data and the select that produced it.
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] dat;
    } beat_t;

    // Occupancy of the main + skid pair.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;
    beat_t  main_q,  main_d;
    beat_t  skid_q,  skid_d;
    logic   in_rdy_q,  in_rdy_d;
    logic   out_vld_q, out_vld_d;

    logic       acc;
    logic       dlv;
    logic [WIDTH-1:0] sel_dat;
    beat_t      new_beat;

    // ------------------------------------------------------------------
    // Input select. Data defaults to zero, so any select value with no
    // matching input (only reachable when NUM_IN is not a power of two)
    // captures all zeros without extra logic.
    // ------------------------------------------------------------------
    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_dat = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        new_beat     = '0;
        new_beat.sel = in_sel;
        new_beat.dat = sel_dat;
    end

    // Handshakes use only registered flags, so neither ready nor valid
    // ever depends combinationally on the opposite side.
    assign acc = in_valid  & in_rdy_q;
    assign dlv = out_vld_q & out_ready;

    // ------------------------------------------------------------------
    // Occupancy / data movement
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    main_d  = new_beat;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && dlv) begin
                    // Main is draining this cycle, so the new beat replaces it.
                    main_d = new_beat;
                end else if (acc) begin
                    // Main is stalled; park the new beat behind it.
                    skid_d  = new_beat;
                    state_d = ST_FULL;
                end else if (dlv) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a delivery can happen.
                if (dlv) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush wins over everything, including an accept in the same cycle.
        // Storage contents are left alone; out_valid low makes them invisible.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end

        out_vld_d = (state_d != ST_EMPTY);
        in_rdy_d  = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = out_vld_q;
    assign out_data  = main_q.dat;
    assign out_sel   = main_q.sel;

`ifdef PIPE_MUX_RANGE_CHK_EN
    // ------------------------------------------------------------------
    // Sticky range checker: records any accepted beat whose select had no
    // matching input. Only reset clears it; flush deliberately does not,
    // so a squashed bad beat is still reported.
    // ------------------------------------------------------------------
    logic sel_oob;
    logic sel_err_q, sel_err_d;

    always_comb begin
        sel_oob = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_oob = 1'b0;
            end
        end
    end

    always_comb begin
        sel_err_d = sel_err_q | (acc & sel_oob);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_pipe_mux_sel.sv
`timescale 1ns/1ps
module tb_pipe_mux_sel;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // 4-input instance
    logic [4*W-1:0] in_data;
    logic [1:0]     in_sel;
    logic           in_valid, in_ready, flush;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_valid, out_ready;
`ifdef PIPE_MUX_RANGE_CHK_EN
    logic           sel_err;
`endif

    // 3-input instance (non power of two, out-of-range select reachable)
    logic [3*W-1:0] in_data3;
    logic [1:0]     in_sel3;
    logic           in_valid3, in_ready3, flush3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_sel3;
    logic           out_valid3, out_ready3;
`ifdef PIPE_MUX_RANGE_CHK_EN
    logic           sel_err3;
`endif

    pipe_mux_sel #(.WIDTH(W), .NUM_IN(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
`ifdef PIPE_MUX_RANGE_CHK_EN
        .sel_err(sel_err),
`endif
        .out_ready(out_ready)
    );

    pipe_mux_sel #(.WIDTH(W), .NUM_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_sel(in_sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
        .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
`ifdef PIPE_MUX_RANGE_CHK_EN
        .sel_err(sel_err3),
`endif
        .out_ready(out_ready3)
    );

    int tests = 0;
    int fails = 0;

    // Reference model for the 4-input instance: an ordered queue of held
    // beats, capacity two. Ready = room in the queue, valid = queue non-empty.
    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   s;
    } beat_t;
    beat_t q[$];
    logic [W-1:0] src[4];

    // Advance one clock: inputs are presented, the model applies the
    // handshake rules on the edge, and control returns at the next negedge.
    task automatic cycle();
        bit    acc, dlv;
        beat_t b;
        in_data = {src[3], src[2], src[1], src[0]};
        acc = in_valid && (q.size() < 2);
        dlv = out_ready && (q.size() > 0);
        b.d = src[in_sel];
        b.s = in_sel;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (dlv) void'(q.pop_front());
            if (acc) q.push_back(b);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; in_sel = 0; flush = 0; out_ready = 0; in_data = '0;
        in_valid3 = 0; in_sel3 = 0; flush3 = 0; out_ready3 = 0; in_data3 = '0;
        for (int k = 0; k < 4; k++) src[k] = '0;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
        tests++; if (out_sel !== 2'd0) begin fails++; $display("FAIL reset_out_sel got %0d want 0", out_sel); end
        tests++; if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1) begin fails++; $display("FAIL reset_dut3 got v=%b r=%b want v=0 r=1", out_valid3, in_ready3); end
`ifdef PIPE_MUX_RANGE_CHK_EN
        tests++; if (sel_err !== 1'b0 || sel_err3 !== 1'b0) begin fails++; $display("FAIL reset_sel_err got %b/%b want 0/0", sel_err, sel_err3); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        int           seq[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
        logic [W-1:0] exp[8] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h44, 32'h33, 32'h22, 32'h11};
        src[0] = 32'h11; src[1] = 32'h22; src[2] = 32'h33; src[3] = 32'h44;
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            in_sel = 2'(seq[i]);
            in_valid = 1;
            cycle();
            tests++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_sel !== 2'(seq[i]) || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL stream_beat%0d got v=%b d=%h s=%0d r=%b want v=1 d=%h s=%0d r=1",
                         i, out_valid, out_data, out_sel, in_ready, exp[i], seq[i]);
            end
        end
        in_valid = 0;
        cycle();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain got v=%b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        in_valid = 1;
        in_sel = 1; cycle();
        tests++; if (in_ready !== 1'b1 || out_data !== 32'h22) begin fails++; $display("FAIL bp_first got r=%b d=%h want r=1 d=22", in_ready, out_data); end
        in_sel = 2; cycle();
        tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_full got r=%b v=%b want r=0 v=1", in_ready, out_valid); end
        in_sel = 3; cycle();
        tests++; if (in_ready !== 1'b0 || out_data !== 32'h22) begin fails++; $display("FAIL bp_hold got r=%b d=%h want r=0 d=22", in_ready, out_data); end
        out_ready = 1; cycle();
        tests++; if (out_valid !== 1'b1 || out_data !== 32'h33 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_skid_move got v=%b d=%h r=%b want v=1 d=33 r=1", out_valid, out_data, in_ready); end
        cycle();
        tests++; if (out_valid !== 1'b1 || out_data !== 32'h44 || out_sel !== 2'd3) begin fails++; $display("FAIL bp_third got v=%b d=%h s=%0d want v=1 d=44 s=3", out_valid, out_data, out_sel); end
        in_valid = 0; cycle();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got v=%b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 0;
        in_valid = 1;
        in_sel = 2; cycle();
        in_sel = 3; cycle();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_prefill got r=%b want 0", in_ready); end
        in_sel = 0; flush = 1; cycle();
        flush = 0; in_valid = 0;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_clear got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        out_ready = 1; cycle();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_ghost got v=%b d=%h want v=0", out_valid, out_data); end
    endtask

    task automatic test_range();
        in_data3 = {32'h33, 32'h22, 32'h11};
        out_ready3 = 1;
        in_valid3 = 1; in_sel3 = 3; cycle();
        tests++; if (out_valid3 !== 1'b1 || out_data3 !== '0 || out_sel3 !== 2'd3) begin fails++; $display("FAIL range_oob got v=%b d=%h s=%0d want v=1 d=0 s=3", out_valid3, out_data3, out_sel3); end
`ifdef PIPE_MUX_RANGE_CHK_EN
        tests++; if (sel_err3 !== 1'b1) begin fails++; $display("FAIL range_sel_err_set got %b want 1", sel_err3); end
`endif
        in_sel3 = 2; cycle();
        tests++; if (out_valid3 !== 1'b1 || out_data3 !== 32'h33) begin fails++; $display("FAIL range_inrange got v=%b d=%h want v=1 d=33", out_valid3, out_data3); end
        in_valid3 = 0; flush3 = 1; cycle();
        flush3 = 0;
        tests++; if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1) begin fails++; $display("FAIL range_flush got v=%b r=%b want v=0 r=1", out_valid3, in_ready3); end
`ifdef PIPE_MUX_RANGE_CHK_EN
        cycle();
        tests++; if (sel_err3 !== 1'b1) begin fails++; $display("FAIL range_sel_err_sticky got %b want 1", sel_err3); end
`endif
    endtask

    task automatic test_async_reset();
        src[0] = 32'hA0; src[1] = 32'hA1; src[2] = 32'hA2; src[3] = 32'hA3;
        out_ready = 0;
        in_valid = 1;
        in_sel = 1; cycle();
        in_sel = 2; cycle();
        in_valid = 0;
        tests++; if (in_ready !== 1'b0 || out_data !== 32'hA1) begin fails++; $display("FAIL areset_prefill got r=%b d=%h want r=0 d=a1", in_ready, out_data); end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            fails++;
            $display("FAIL areset_immediate got v=%b r=%b d=%h want v=0 r=1 d=0", out_valid, in_ready, out_data);
        end
`ifdef PIPE_MUX_RANGE_CHK_EN
        tests++; if (sel_err3 !== 1'b0) begin fails++; $display("FAIL areset_sel_err got %b want 0", sel_err3); end
`endif
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 4; k++) src[k] = $urandom;
            in_sel    = 2'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
            tests++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2) ||
                (q.size() != 0 && (out_data !== q[0].d || out_sel !== q[0].s))) begin
                fails++;
                if (bad < 10)
                    $display("FAIL random_cyc%0d got v=%b r=%b d=%h s=%0d want v=%b r=%b d=%h s=%0d",
                             i, out_valid, in_ready, out_data, out_sel, (q.size() != 0), (q.size() < 2),
                             (q.size() != 0) ? q[0].d : '0, (q.size() != 0) ? q[0].s : 2'd0);
                bad++;
            end
        end
        flush = 0;
        in_valid = 0;
`ifdef PIPE_MUX_RANGE_CHK_EN
        tests++; if (sel_err !== 1'b0) begin fails++; $display("FAIL random_sel_err got %b want 0", sel_err); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_range();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_mux_sel.md
# pipe_mux_sel

Registered, parametrised N-input, W-bit select stage with valid/ready flow control and a two-entry skid buffer. Generalises the fixed four-input 1-bit ALU result mux to any width and input count. Output is registered, so it breaks timing and can sit directly on a pipeline stage boundary, such as EX result select or a forwarding-operand select. Backpressure from the next stage stalls it losslessly; `flush` squashes in-flight beats on branch/exception.

## Interface
Parameters:
- `WIDTH`, 32, data bits per input.
- `NUM_IN`, 4, number of inputs; legal range 2..16.
- `SEL_W`, `$clog2(NUM_IN)`, select width; derived, do not override.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_data`  in  NUM_IN*WIDTH  packed inputs; input k is bits [k*WIDTH +: WIDTH].
- `in_sel`  in  SEL_W  selects the input for the current beat.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat.
- `flush`  in  1  synchronous squash of all held beats.
- `out_data`  out  WIDTH  selected, registered data.
- `out_sel`  out  SEL_W  `in_sel` captured with the beat.
- `out_valid`  out  1  output beat present.
- `out_ready`  in  1  downstream accepts.
- `sel_err`  out  1  sticky out-of-range flag; present only with `PIPE_MUX_RANGE_CHK_EN`.

## Operation
- Accept occurs when `in_valid & in_ready`. Delivery occurs when `out_valid & out_ready`.
- At accept, `in_data` slot `in_sel` is captured together with `in_sel`.
- Storage: a main register (drives the outputs) and a skid register. Occupancy is 0, 1 or 2.
- State transitions:
  - EMPTY → ONE on accept.
  - ONE → ONE on simultaneous accept and delivery. The new beat goes straight to the main register.
  - ONE → FULL on accept without delivery. The new beat goes to the skid register.
  - ONE → EMPTY on delivery without accept.
  - FULL → ONE on delivery. The skid beat moves to the main register.
- `in_ready` = not FULL. It is registered, with no combinational path from `out_ready`. Accept is impossible while FULL.
- Beat order is strictly preserved. No beat is dropped or duplicated.
- Out-of-range select (`in_sel >= NUM_IN`, only possible when NUM_IN is not a power of 2): the captured data is all zeros.
- `flush`:
  - Forces state to EMPTY at the next edge.
  - Any accept in that same cycle is discarded.
  - `out_valid` is 0 the following cycle.
  - `in_ready` is 1 the following cycle.
- Reset mid-operation: all beats are lost and state returns to EMPTY immediately (asynchronous).

## Timing
- Latency is 1 cycle. A beat accepted at edge N is visible on `out_*` after edge N, given the stage was EMPTY, or ONE with a delivery in that cycle.
- Throughput is 1 beat/cycle while `out_ready` stays 1.
- Reset values:
  - `out_valid`=0, `in_ready`=1, `out_data`=0, `out_sel`=0, `sel_err`=0.
  - Skid register contents = 0.
- `out_data` and `out_sel` are held stable while `out_valid & !out_ready`.
- Upstream and downstream may change their signals freely when no transfer occurs. No combinational path exists from input signals to output signals.

## Configuration
- Macro: `PIPE_MUX_RANGE_CHK_EN`.
- Defined:
  - Port `sel_err` exists.
  - It sets to 1 on the edge that accepts a beat with `in_sel >= NUM_IN`.
  - It stays 1 until `rst_n` is asserted. `flush` does not clear it.
  - The zero-data behaviour is unchanged.
- Undefined: no `sel_err` port and no checker logic. Out-of-range selects silently produce zero data.

## Test plan
- Streaming (WIDTH=32, NUM_IN=4, inputs 0x11, 0x22, 0x33, 0x44): 8 beats with `in_sel` 0,1,2,3,3,2,1,0 and `out_ready`=1 → out_data 0x11, 0x22, 0x33, 0x44, 0x44, 0x33, 0x22, 0x11, each one cycle after accept, with no bubbles.
- Backpressure: hold `out_ready`=0 and offer 3 beats (sel 1, 2, 3).
  - Exactly 2 are accepted, then `in_ready`=0.
  - After `out_ready`=1, the outputs are 0x22 then 0x33, and the third beat (0x44) is accepted.
- Flush when FULL, with `in_valid`=1 in the same cycle → next cycle `out_valid`=0 and `in_ready`=1. The flush-cycle beat never appears.
- NUM_IN=3, `in_sel`=3 → `out_data`=0. With the macro defined, `sel_err` rises and stays at 1 after a following flush, clearing only on reset.
- Async reset: assert `rst_n`=0 mid-cycle while FULL → `out_valid`=0, `in_ready`=1, `out_data`=0 immediately, without waiting for a clock edge.
